// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - slice mode constants and occupancy sizing for the register chain
package pipe_pkg;

    localparam int MODE_FWD  = 0;
    localparam int MODE_BWD  = 1;
    localparam int MODE_FULL = 2;

    // A full slice holds up to two beats; the others hold one.
    function automatic int occ_width(input int depth, input int mode);
        int cap;
        cap = (mode == MODE_FULL) ? 2 * depth : depth;
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - one valid/ready register slice: forward, skid, or skid feeding forward
module pipe_slice
    import pipe_pkg::*;
#(
    parameter int L    = 8,
    parameter int MODE = MODE_FULL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [L-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [L-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   held
);

    logic         sv;
    logic         v;
    logic         mid_valid;
    logic         mid_ready;
    logic [L-1:0] mid_data;

    if (MODE != MODE_FWD) begin : g_skid
        logic [L-1:0] sd;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sv <= 1'b0;
                sd <= '0;
            end else if (flush) begin
                sv <= 1'b0;
            end else if (in_valid && !sv && !mid_ready) begin
                sv <= 1'b1;
                sd <= in_data;
            end else if (mid_ready && sv) begin
                sv <= 1'b0;
            end
        end

        assign in_ready  = ~sv;
        assign mid_valid = in_valid | sv;
        assign mid_data  = sv ? sd : in_data;
    end else begin : g_no_skid
        assign sv        = 1'b0;
        assign in_ready  = mid_ready;
        assign mid_valid = in_valid;
        assign mid_data  = in_data;
    end

    if (MODE != MODE_BWD) begin : g_fwd
        logic [L-1:0] d;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v <= 1'b0;
                d <= '0;
            end else if (flush) begin
                v <= 1'b0;
            end else if (mid_ready) begin
                v <= mid_valid;
                if (mid_valid) begin
                    d <= mid_data;
                end
            end
        end

        assign mid_ready = out_ready | ~v;
        assign out_valid = v;
        assign out_data  = d;
    end else begin : g_no_fwd
        assign v         = 1'b0;
        assign mid_ready = out_ready;
        assign out_valid = mid_valid;
        assign out_data  = mid_data;
    end

    assign held = {sv & v, sv ^ v};

endmodule

// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - DEPTH register slices in series with flush and occupancy count
module pipe_chain
    import pipe_pkg::*;
#(
    parameter  int L     = 8,
    parameter  int DEPTH = 2,
    parameter  int MODE  = MODE_FULL,
    localparam int OW    = occ_width(DEPTH, MODE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          valid_f,
    input  logic [L-1:0]  data_f,
    output logic          ready_f,
    output logic          valid_b,
    output logic [L-1:0]  data_b,
    input  logic          ready_b,
    output logic [OW-1:0] occupancy
);

    // Index i is the input of slice i; index DEPTH is the chain output.
    logic         valid [DEPTH+1];
    logic         ready [DEPTH+1];
    logic [L-1:0] data  [DEPTH+1];
    logic [1:0]   held  [DEPTH];

    assign valid[0]     = valid_f;
    assign data[0]      = data_f;
    assign ready_f      = ready[0];
    assign valid_b      = valid[DEPTH];
    assign data_b       = data[DEPTH];
    assign ready[DEPTH] = ready_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
        pipe_slice #(
            .L    (L),
            .MODE (MODE)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (valid[i]),
            .in_data   (data[i]),
            .in_ready  (ready[i]),
            .out_valid (valid[i+1]),
            .out_data  (data[i+1]),
            .out_ready (ready[i+1]),
            .held      (held[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OW'(held[i]);
        end
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised valid/ready register chain: DEPTH identical slices in series, each slice a forward-registered, backward-registered (skid) or full register slice, selected by MODE.
- Used between bus masters and slaves to cut timing paths on data/valid, on ready, or on both.
- Adds a synchronous flush and an occupancy count for debug and drain control.

Parameters:
- L, 8, data width in bits (>=1).
- DEPTH, 2, number of slices in series (>=1).
- MODE, 2, slice type: 0 = forward (valid/data registered), 1 = backward (ready registered, skid), 2 = full (all three registered).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all held beats.
- valid_f  in  1  upstream beat valid.
- data_f  in  L  upstream beat data.
- ready_f  out  1  chain can accept upstream beat.
- valid_b  out  1  downstream beat valid.
- data_b  out  L  downstream beat data.
- ready_b  in  1  downstream accepts beat.
- occupancy  out  OW  beats currently held in chain registers. OW = $clog2(CAP+1); CAP = DEPTH (MODE 0/1) or 2*DEPTH (MODE 2).

Behaviour:
- Reset (rst low, asynchronous): all valid and skid-valid bits 0, all data registers 0. Outputs: ready_f=1, valid_b=0, occupancy=0. data_b=0 for MODE 0/2; data_b=data_f for MODE 1 (combinational pass-through).
- Transfer: a beat moves across an interface only on a clock edge where valid and ready are both 1.
- Upstream must hold valid_f/data_f while ready_f=0; the chain does not check this.
- Guarantees at the output: no loss, no duplication, strict order. data_b/valid_b stable while valid_b=1 and ready_b=0.
- Forward slice (MODE 0), per slice:
  - Registers: v, d.
  - in_ready = out_ready | ~v.
  - When in_ready: v <= in_valid.
  - d loads only on an accepted beat (in_valid & in_ready), else holds.
  - Latency 1 cycle per slice; full throughput; ready is combinational through all slices.
- Backward slice (MODE 1), per slice:
  - Registers: sv, sd.
  - in_ready = ~sv (registered).
  - out_valid = in_valid | sv; out_data = sv ? sd : in_data.
  - On in_valid & in_ready & ~out_ready: sv <= 1, sd <= in_data.
  - On out_ready & sv: sv <= 0.
  - Latency 0; full throughput.
- Full slice (MODE 2): backward slice feeding a forward slice inside one slice.
  - Capacity 2.
  - ready, valid and data all come straight from flops.
  - Latency 1 cycle per slice; full throughput with ready_b held high.
- Chain wiring: slice i output drives slice i+1 input; slice 0 faces the *_f ports, slice DEPTH-1 faces the *_b ports.
- Flush (highest priority after reset):
  - On an edge with flush=1, all v/sv bits clear to 0.
  - Data registers hold their values.
  - A beat offered at the input in the same cycle is dropped; any output handshake in that cycle is still counted as delivered.
- occupancy: registered, equals the sum of all v and sv bits after each edge. Never exceeds CAP.
- Boundary cases:
  - Chain full with ready_b=0: ready_f=0 (MODE 1/2 from a flop; MODE 0 combinationally).
  - Simultaneous accept at input and release at output when full: MODE 0 accepts (ready_f=1 via ready_b); MODE 1/2 accept only if the skid is empty.
  - Reset asserted mid-stream: all held beats are discarded at once.

Decomposition:
- Package pipe_pkg holds:
  - constants MODE_FWD=0, MODE_BWD=1, MODE_FULL=2;
  - function occ_width(depth, mode) returning OW.
- Sub-module pipe_slice (parameters L, MODE): one slice with in/out valid/ready/data, flush, and a 2-bit held-count output.
- pipe_chain instantiates DEPTH pipe_slice instances in a generate loop and sums their held counts into occupancy.

Test Plan:
1. MODE=0, DEPTH=2, L=8; stream 0x01..0x10 with ready_b=1 -> first valid_b 2 cycles after first accept; one beat per cycle, in order; occupancy=2 in steady state.
2. MODE=1, DEPTH=1; send 0xA5 with ready_b=1 -> valid_b=1, data_b=0xA5 in the same cycle. Then ready_b=0 while sending 0x3C -> beat captured in skid, ready_f=0 next cycle, occupancy=1. Then ready_b=1 -> 0x3C delivered, ready_f=1.
3. MODE=2, DEPTH=2; ready_b=0, valid_f=1 with data 0x10,0x11,... -> exactly 4 beats accepted, then ready_f=0 and occupancy=4. Release ready_b -> 0x10..0x13 emerge in order.
4. Random valid_f/ready_b (50%), all three modes, DEPTH=3, 2000 beats -> scoreboard shows no loss, no duplication, in order; data_b stable whenever valid_b & ~ready_b.
5. MODE=2, DEPTH=2 holding 3 beats; flush pulse while valid_f=1 with 0x77 -> next edge occupancy=0, valid_b=0, ready_f=1; 0x77 never appears at the output.
6. Assert rst low mid-stream between clock edges -> valid_b=0, ready_f=1, occupancy=0 immediately. After release, the stream resumes with the next new beat only.
